// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reset_seq_pkg
// Brief    : Shared types and default parameter values for the ordered
//            reset-release sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2,
    ERROR    = 2'd3
  } state_t;

  localparam int c_DEF_N_STAGES    = 4;
  localparam int c_DEF_STAGE_DELAY = 8;
  localparam int c_DEF_ACK_TIMEOUT = 64;

  // Width of a stage index; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage : reset_seq_pkg
`default_nettype wire

// File: rtl/reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : reset_seq
// Brief    : Releases N_STAGES downstream reset domains one at a time. Each
//            stage is held for STAGE_DELAY edges, released, then must report
//            ready within ACK_TIMEOUT edges (0 = no limit) before the next
//            stage starts. A missing ack parks the sequencer in ERROR.
// Revision : 1.0 - initial release
// ============================================================================
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int  N_STAGES    = c_DEF_N_STAGES,
  parameter int  STAGE_DELAY = c_DEF_STAGE_DELAY,
  parameter int  ACK_TIMEOUT = c_DEF_ACK_TIMEOUT,
  localparam int IDX_W       = idx_width(N_STAGES)
) (
  input  logic                clock,
  input  logic                reset,
  output logic [N_STAGES-1:0] stage_reset,
  input  logic [N_STAGES-1:0] stage_ready,
  input  logic                soft_req,
  output logic                seq_done,
  output logic                seq_error,
  output logic [IDX_W-1:0]    err_stage
);

  // Terminal counts compare against cnt before it increments, hence the -1
  localparam logic [31:0]      c_HOLD_LAST   = 32'(STAGE_DELAY - 1);
  localparam logic [31:0]      c_ACK_LAST    = 32'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] c_LAST_IDX    = IDX_W'(N_STAGES - 1);
  localparam bit               c_HAS_TIMEOUT = (ACK_TIMEOUT > 0);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [31:0]         r_cnt;
  logic [31:0]         w_cnt_nxt;
  logic [N_STAGES-1:0] r_stage_reset;
  logic [N_STAGES-1:0] w_stage_reset_nxt;
  logic                r_seq_done;
  logic                w_seq_done_nxt;
  logic                r_seq_error;
  logic                w_seq_error_nxt;
  logic [IDX_W-1:0]    r_err_stage;
  logic [IDX_W-1:0]    w_err_stage_nxt;
  logic                w_ready;
  logic                w_restart;

  // Only the ack of the stage currently being waited on matters
  assign w_ready   = stage_ready[r_idx];
  // A re-run request is only meaningful once the sequence has finished
  assign w_restart = soft_req && ((r_state == DONE) || (r_state == ERROR));

  // Next-state and next-output computation for the release sequence
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_cnt_nxt         = r_cnt;
    w_stage_reset_nxt = r_stage_reset;
    w_seq_done_nxt    = r_seq_done;
    w_seq_error_nxt   = r_seq_error;
    w_err_stage_nxt   = r_err_stage;

    unique case (r_state)
      HOLD: begin
        if (r_cnt == c_HOLD_LAST) begin
          w_stage_reset_nxt[r_idx] = 1'b0;
          w_cnt_nxt                = '0;
          w_state_nxt              = WAIT_ACK;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      WAIT_ACK: begin
        // Ready is tested first so an ack on the timeout edge still wins
        if (w_ready) begin
          w_cnt_nxt = '0;
          if (r_idx == c_LAST_IDX) begin
            w_state_nxt    = DONE;
            w_seq_done_nxt = 1'b1;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (c_HAS_TIMEOUT && (r_cnt == c_ACK_LAST)) begin
          w_state_nxt     = ERROR;
          w_seq_error_nxt = 1'b1;
          w_err_stage_nxt = r_idx;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      DONE: begin
        w_stage_reset_nxt = '0;
        w_seq_done_nxt    = 1'b1;
      end
      ERROR: begin
        w_seq_error_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = HOLD;
      end
    endcase

    // Re-run looks exactly like a fresh reset release
    if (w_restart) begin
      w_state_nxt       = HOLD;
      w_idx_nxt         = '0;
      w_cnt_nxt         = '0;
      w_stage_reset_nxt = '1;
      w_seq_done_nxt    = 1'b0;
      w_seq_error_nxt   = 1'b0;
      w_err_stage_nxt   = '0;
    end
  end

  // State and output registers; reset overrides every other input
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= HOLD;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_stage_reset <= '1;
      r_seq_done    <= 1'b0;
      r_seq_error   <= 1'b0;
      r_err_stage   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_cnt         <= w_cnt_nxt;
      r_stage_reset <= w_stage_reset_nxt;
      r_seq_done    <= w_seq_done_nxt;
      r_seq_error   <= w_seq_error_nxt;
      r_err_stage   <= w_err_stage_nxt;
    end
  end

  assign stage_reset = r_stage_reset;
  assign seq_done    = r_seq_done;
  assign seq_error   = r_seq_error;
  assign err_stage   = r_err_stage;

endmodule : reset_seq
`default_nettype wire

// File: tb/tb_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_seq
// Brief    : Scoreboard bench for reset_seq (N_STAGES=4, STAGE_DELAY=3,
//            ACK_TIMEOUT=10): directed timeline scenarios plus random traffic
//            against a timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_seq;

  localparam int P_N  = 4;
  localparam int P_D  = 3;
  localparam int P_TO = 10;

  typedef struct packed {
    logic [3:0] sr;
    logic       done;
    logic       err;
    logic [1:0] es;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       soft_req;
  logic [3:0] stage_ready;
  logic [3:0] stage_reset;
  logic       seq_done;
  logic       seq_error;
  logic [1:0] err_stage;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];

  // Reference model: everything measured as absolute edge numbers since the
  // most recent reset / honoured re-run (which is edge 0).
  int         m_e;
  int         m_k;
  int         m_mark;
  bit         m_wait;
  bit         m_done;
  bit         m_err;
  int         m_errst;
  logic [3:0] m_sr;

  reset_seq #(
    .N_STAGES   (P_N),
    .STAGE_DELAY(P_D),
    .ACK_TIMEOUT(P_TO)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .stage_reset(stage_reset),
    .stage_ready(stage_ready),
    .soft_req   (soft_req),
    .seq_done   (seq_done),
    .seq_error  (seq_error),
    .err_stage  (err_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_restart();
    m_e = 0; m_k = 0; m_mark = 0; m_wait = 0;
    m_done = 0; m_err = 0; m_errst = 0; m_sr = 4'b1111;
  endfunction

  function automatic void model_step(input logic r, input logic s, input logic [3:0] rdy);
    if (r) begin
      model_restart();
    end else if (m_done || m_err) begin
      if (s) model_restart();
    end else begin
      m_e++;
      if (!m_wait) begin
        if (m_e - m_mark == P_D) begin
          m_sr[m_k] = 1'b0;
          m_wait    = 1;
          m_mark    = m_e;
        end
      end else if (rdy[m_k]) begin
        if (m_k == P_N - 1) begin
          m_done = 1;
        end else begin
          m_k++;
          m_wait = 0;
          m_mark = m_e;
        end
      end else if ((P_TO > 0) && (m_e - m_mark == P_TO)) begin
        m_err   = 1;
        m_errst = m_k;
      end
    end
  endfunction

  // One clock of stimulus; the matching expectation goes to the scoreboard
  task automatic step(input logic r, input logic s, input logic [3:0] rdy);
    exp_t x;
    @(negedge clk);
    reset = r; soft_req = s; stage_ready = rdy;
    @(posedge clk);
    model_step(r, s, rdy);
    x.sr = m_sr; x.done = m_done; x.err = m_err; x.es = 2'(m_errst);
    sb_q.push_back(x);
  endtask

  // Spec timeline with all acks present: stage k drops after edge 3+4k,
  // seq_done after edge 16
  task automatic check_timeline(input int e);
    logic [3:0] exp_sr;
    #1;
    for (int k = 0; k < 4; k++) exp_sr[k] = (e < 3 + 4 * k);
    chk("tl_stage_reset", 32'(stage_reset), 32'(exp_sr));
    chk("tl_seq_done", 32'(seq_done), 32'(e >= 16));
  endtask

  // Scoreboard monitor: compares every queued expectation once outputs settle
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk("sb_stage_reset", 32'(stage_reset), 32'(x.sr));
        chk("sb_seq_done",    32'(seq_done),    32'(x.done));
        chk("sb_seq_error",   32'(seq_error),   32'(x.err));
        chk("sb_err_stage",   32'(err_stage),   32'(x.es));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int pct;
    logic [3:0] rdy;
    reset = 1'b1; soft_req = 1'b0; stage_ready = 4'b1111;
    model_restart();

    // Normal sequence: reset for 5 cycles, all acks present
    repeat (5) step(1'b1, 1'b0, 4'b1111);
    #1;
    chk("rst_stage_reset", 32'(stage_reset), 32'hF);
    chk("rst_seq_done", 32'(seq_done), 32'h0);
    chk("rst_seq_error", 32'(seq_error), 32'h0);
    for (int e = 1; e <= 20; e++) begin
      step(1'b0, 1'b0, 4'b1111);
      check_timeline(e);
    end

    // Stage 2 never acks: timeout at edge 21, stage 3 stays in reset
    repeat (2) step(1'b1, 1'b0, 4'b1011);
    for (int e = 1; e <= 25; e++) begin
      step(1'b0, 1'b0, 4'b1011);
      #1;
      if (e == 10) chk("to_sr2_before", 32'(stage_reset[2]), 32'h1);
      if (e == 11) chk("to_sr2_after", 32'(stage_reset[2]), 32'h0);
      if (e == 20) chk("to_err_before", 32'(seq_error), 32'h0);
      if (e == 21) chk("to_err_after", 32'(seq_error), 32'h1);
      if (e == 21) chk("to_err_stage", 32'(err_stage), 32'h2);
      if (e == 25) chk("to_sr3_held", 32'(stage_reset), 32'h8);
    end
    // Re-run from ERROR clears everything
    step(1'b0, 1'b1, 4'b1011);
    #1;
    chk("err_soft_sr", 32'(stage_reset), 32'hF);
    chk("err_soft_error", 32'(seq_error), 32'h0);
    chk("err_soft_stage", 32'(err_stage), 32'h0);

    // Ack arrives exactly on the timeout edge: ready wins
    step(1'b1, 1'b0, 4'b1011);
    for (int e = 1; e <= 26; e++) begin
      step(1'b0, 1'b0, (e >= 21) ? 4'b1111 : 4'b1011);
      #1;
      if (e == 21) chk("race_no_err", 32'(seq_error), 32'h0);
      if (e == 23) chk("race_sr3_before", 32'(stage_reset[3]), 32'h1);
      if (e == 24) chk("race_sr3_after", 32'(stage_reset[3]), 32'h0);
      if (e == 25) chk("race_done", 32'(seq_done), 32'h1);
    end

    // Reset pulse while waiting on stage 1's ack aborts the sequence
    step(1'b1, 1'b0, 4'b1101);
    for (int e = 1; e <= 9; e++) step(1'b0, 1'b0, 4'b1101);
    step(1'b1, 1'b0, 4'b1101);
    #1;
    chk("abort_sr", 32'(stage_reset), 32'hF);
    chk("abort_done", 32'(seq_done), 32'h0);
    for (int e = 1; e <= 20; e++) begin
      step(1'b0, 1'b0, 4'b1111);
      check_timeline(e);
    end

    // Re-run from DONE replays the timeline; requests mid-sequence are ignored
    step(1'b0, 1'b1, 4'b1111);
    #1;
    chk("soft_sr", 32'(stage_reset), 32'hF);
    chk("soft_done", 32'(seq_done), 32'h0);
    for (int e = 1; e <= 20; e++) begin
      step(1'b0, (e == 2 || e == 4 || e == 9), 4'b1111);
      check_timeline(e);
    end

    // Random traffic against the model
    pct = 100;
    for (int c = 0; c < 4000; c++) begin
      if (c % 40 == 0) begin
        case ($urandom_range(0, 3))
          0:       pct = 0;
          1:       pct = 5;
          2:       pct = 30;
          default: pct = 100;
        endcase
      end
      for (int b = 0; b < 4; b++) rdy[b] = ($urandom_range(0, 99) < pct);
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 19) == 0), rdy);
    end

    repeat (2) @(posedge clk);
    #2;
    if (sb_q.size() != 0) chk("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_reset_seq
`default_nettype wire

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 N_STAGES, 4, number of downstream reset domains released in order; legal range 1..16.
REQ-002 STAGE_DELAY, 8, clock edges held before each stage release; must be >= 1.
REQ-003 ACK_TIMEOUT, 64, edges allowed for a released stage to report ready; 0 = wait forever.
REQ-004 clock  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset (typically driven by the team's reset generator).
REQ-006 stage_reset  output  N_STAGES  per-stage active-high reset; bit k releases k-th.
REQ-007 stage_ready  input  N_STAGES  per-stage "out of reset and ready" acknowledge.
REQ-008 soft_req  input  1  single-cycle request to re-run the sequence.
REQ-009 seq_done  output  1  all stages released and acknowledged.
REQ-010 seq_error  output  1  sticky ack-timeout flag.
REQ-011 err_stage  output  IDX_W  index of the timed-out stage; IDX_W = max(1, clog2(N_STAGES)).

Function
REQ-012 States: HOLD, WAIT_ACK, DONE, ERROR; stage index idx and 32-bit counter cnt.
REQ-013 Edge 1 is the first rising edge sampling reset=0.
REQ-014 HOLD:
- cnt increments each edge.
- On the STAGE_DELAY-th HOLD edge: clear stage_reset[idx], zero cnt, go to WAIT_ACK.
REQ-015 WAIT_ACK samples only stage_ready[idx]; other ready bits are ignored.
REQ-016 WAIT_ACK when stage_ready[idx]=1:
- idx==N_STAGES-1: go to DONE.
- Otherwise: increment idx, zero cnt, go to HOLD.
REQ-017 WAIT_ACK timeout: with ACK_TIMEOUT>0, if the ACK_TIMEOUT-th WAIT_ACK edge samples ready=0, go to ERROR, set seq_error=1 and err_stage=idx.
REQ-018 Ready and timeout on the same edge: ready wins; no error.
REQ-019 DONE: seq_done=1; all stage_reset bits 0.
REQ-020 ERROR: stages already released stay released; unreleased stages stay in reset; seq_error and err_stage hold.
REQ-021 soft_req is honoured only in DONE or ERROR. On the next edge:
- all stage_reset=1.
- seq_done=0, seq_error=0, err_stage=0.
- idx=0, cnt=0, state=HOLD.
- Timing then matches a post-reset sequence, counting that edge as edge 0.
REQ-022 soft_req in HOLD or WAIT_ACK is ignored.
REQ-023 A released stage is never re-asserted except by reset or an honoured soft_req.
REQ-024 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-025 reset=1 at an edge forces, from any state:
- stage_reset=all ones.
- seq_done=0, seq_error=0, err_stage=0.
- idx=0, cnt=0, state=HOLD.
REQ-026 A reset asserted mid-sequence aborts the sequence; release restarts from stage 0 with the timing of REQ-014.
REQ-027 reset has priority over soft_req and stage_ready.

Structure
REQ-028 Package reset_seq_pkg holds:
- the state enum (HOLD, WAIT_ACK, DONE, ERROR).
- default values of STAGE_DELAY and ACK_TIMEOUT.
REQ-029 Single flat module; counter and FSM inline; no sub-module.

Verification (N_STAGES=4, STAGE_DELAY=3, ACK_TIMEOUT=10)
REQ-030 reset high 5 cycles, stage_ready tied 4'b1111 ->
- stage_reset[k] falls after edge 3+4k (edges 3, 7, 11, 15).
- seq_done rises after edge 16.
REQ-031 stage_ready[2] held 0, others 1 ->
- stage_reset[2] falls after edge 11.
- seq_error=1 and err_stage=2 after edge 21.
- stage_reset[3] remains 1.
REQ-032 Same as REQ-031, but stage_ready[2] asserted exactly at edge 21 -> no error; stage_reset[3] falls after edge 24.
REQ-033 reset pulsed 1 cycle during stage-1 WAIT_ACK -> next edge all stage_reset=1, seq_done=0; post-release timing identical to REQ-030.
REQ-034 soft_req in DONE -> next edge stage_reset=4'b1111; sequence replays with REQ-030 timing. soft_req pulsed during HOLD -> no effect.
